// File: rtl/cdb_arbiter_if.sv
// Bundle of FU result handshake and CDB broadcast signals for cdb_arbiter.
// master = functional-unit/consumer side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int unsigned N_SRC    = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ROB_IX_W = 3
);
  logic [N_SRC-1:0]          valid_in;
  logic [N_SRC*DATA_W-1:0]   data_in;
  logic [N_SRC*ROB_IX_W-1:0] rob_idx_in;
  logic [N_SRC-1:0]          read_out;
  logic                      cdb_valid_out;
  logic [DATA_W-1:0]         cdb_value_out;
  logic [ROB_IX_W-1:0]       cdb_rob_ix_out;

  modport master (
    output valid_in, data_in, rob_idx_in,
    input  read_out, cdb_valid_out, cdb_value_out, cdb_rob_ix_out
  );

  modport slave (
    input  valid_in, data_in, rob_idx_in,
    output read_out, cdb_valid_out, cdb_value_out, cdb_rob_ix_out
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: one FU acknowledged per cycle, result broadcast next cycle.
// Optional CDB_PERF_CNT_EN adds grant and conflict counters.
module cdb_arbiter #(
  parameter int unsigned N_SRC    = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ROB_IX_W = 3
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          flush_in,
  cdb_arbiter_if.slave  bus
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]   grant_count_out,
  output logic [31:0]   conflict_count_out
`endif
);

  localparam int unsigned PtrW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]     grant_idx;
  logic                grant_vld;
  logic [DATA_W-1:0]   data_sel;
  logic [ROB_IX_W-1:0] tag_sel;

  logic                cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0]   cdb_value_q, cdb_value_d;
  logic [ROB_IX_W-1:0] cdb_tag_q, cdb_tag_d;

  // Scan from rr_ptr upwards, modulo N_SRC; first valid source wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!grant_vld && bus.valid_in[idx[PtrW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[PtrW-1:0];
      end
    end
    if (rst_in || flush_in) grant_vld = 1'b0;
  end

  always_comb begin
    data_sel = '0;
    tag_sel  = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (grant_idx == PtrW'(k)) begin
        data_sel = bus.data_in[k*DATA_W +: DATA_W];
        tag_sel  = bus.rob_idx_in[k*ROB_IX_W +: ROB_IX_W];
      end
    end
  end

  always_comb begin
    bus.read_out = '0;
    if (grant_vld) bus.read_out[grant_idx] = 1'b1;
  end

  always_comb begin
    cdb_valid_d = grant_vld;
    cdb_value_d = cdb_value_q;
    cdb_tag_d   = cdb_tag_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_vld) begin
      cdb_value_d = data_sel;
      cdb_tag_d   = tag_sel;
      rr_ptr_d    = (grant_idx == PtrW'(N_SRC - 1)) ? '0 : grant_idx + PtrW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_value_q <= '0;
      cdb_tag_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_value_q <= cdb_value_d;
      cdb_tag_q   <= cdb_tag_d;
    end
  end

  assign bus.cdb_valid_out  = cdb_valid_q;
  assign bus.cdb_value_out  = cdb_value_q;
  assign bus.cdb_rob_ix_out = cdb_tag_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] grant_cnt_q, conflict_cnt_q;
  logic        multi_vld;

  assign multi_vld = ($countones(bus.valid_in) > 1);

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (grant_vld) grant_cnt_q <= grant_cnt_q + 32'd1;
      if (multi_vld && !flush_in) conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign grant_count_out    = grant_cnt_q;
  assign conflict_count_out = conflict_cnt_q;
`endif

endmodule
